// File: rtl/ysyx_axi4_pkg.sv
// Shared AXI4 encodings, channel FSM state types and address/legality helpers
// for the AXI4 memory slave.
package ysyx_axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] bytes);
        return (addr >= base) && ((addr - base) < bytes);
    endfunction

    function automatic logic burst_legal(input logic [1:0] burst,
                                         input logic [2:0] size,
                                         input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size <= 3'd3) && (burst != 2'b11) && ((burst != BURST_WRAP) || wrap_len_ok);
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ysyx_axi4_burst_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module ysyx_axi4_burst_addr
    import ysyx_axi4_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_W'(1) << size;
        incr_addr = addr + step;
        // wrap boundary is (len+1) beats of 1<<size bytes; legal lengths make it a power of two
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/ysyx_axi4_mem_slave.sv
// AXI4 slave backed by a 64-bit register array, with independent read and
// write channel FSMs, programmable first-beat read latency and byte strobes.
//
//   state  | meaning
//   R_IDLE | arready high, waiting for a read address
//   R_WAIT | first-beat latency countdown
//   R_DATA | rvalid high, beat held until rready
//   W_IDLE | awready high, waiting for a write address
//   W_DATA | wready high, accepting write beats
//   W_RESP | bvalid high, held until bready
module ysyx_axi4_mem_slave
    import ysyx_axi4_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 64,
    parameter int                ID_W       = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                MEM_BYTES  = 65536,
    parameter int                RD_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int         WORDS    = MEM_BYTES / 8;
    localparam int         IDX_W    = $clog2(WORDS);
    localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY - 1);

    logic [DATA_W-1:0] mem [WORDS];
    logic              run_q;

    function automatic logic [1:0] beat_resp(input logic [ADDR_W-1:0] addr,
                                             input logic [1:0]        burst,
                                             input logic [2:0]        size,
                                             input logic [7:0]        len);
        logic [1:0] r;
        r = RESP_OKAY;
        if (!burst_legal(burst, size, len))
            r = RESP_SLVERR;
        if (!addr_in_range(64'(addr), 64'(BASE_ADDR), 64'(MEM_BYTES)))
            r = RESP_DECERR;
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return off[IDX_W+2:3];
    endfunction

    // holds both ready outputs low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // ---------------- read channel ----------------
    rd_state_e         rd_state, rd_state_nxt;
    logic [ID_W-1:0]   rd_id;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nxt, rd_fetch_addr;
    logic [7:0]        rd_len, rd_beat;
    logic [2:0]        rd_size;
    logic [1:0]        rd_burst, rd_fetch_resp, rresp_q;
    logic [3:0]        rd_lat;
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  rd_idx;
    logic              ar_hs, r_hs, rd_last_beat, rd_load;

    ysyx_axi4_burst_addr #(.ADDR_W(ADDR_W)) u_rd_addr (
        .addr      (rd_addr),
        .size      (rd_size),
        .len       (rd_len),
        .burst     (rd_burst),
        .next_addr (rd_addr_nxt)
    );

    assign ar_hs        = arvalid && arready;
    assign r_hs         = rvalid && rready;
    assign rd_last_beat = (rd_beat == rd_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= R_IDLE;
        else        rd_state <= rd_state_nxt;
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_nxt = (RD_LATENCY == 0) ? R_DATA : R_WAIT;
            R_WAIT:  if (rd_lat == 4'd0) rd_state_nxt = R_DATA;
            R_DATA:  if (r_hs && rd_last_beat) rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        case (rd_state)
            R_IDLE:  arready = run_q;
            R_DATA:  begin
                rvalid = 1'b1;
                rlast  = rd_last_beat;
            end
            default: ;
        endcase
    end

    assign rid   = rd_id;
    assign rdata = rvalid ? rdata_q : '0;
    assign rresp = rvalid ? rresp_q : '0;

    // beat data is fetched into a register as the beat becomes valid, so it
    // stays stable under backpressure and sees pre-write contents
    assign rd_load = (rd_state_nxt == R_DATA) && ((rd_state != R_DATA) || rready);

    always_comb begin
        rd_fetch_addr = rd_addr_nxt;
        if (rd_state == R_IDLE)      rd_fetch_addr = araddr;
        else if (rd_state == R_WAIT) rd_fetch_addr = rd_addr;
    end

    assign rd_fetch_resp = (rd_state == R_IDLE) ? beat_resp(rd_fetch_addr, arburst, arsize, arlen)
                                                : beat_resp(rd_fetch_addr, rd_burst, rd_size, rd_len);
    assign rd_idx = word_idx(rd_fetch_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_id    <= '0;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
            rd_beat  <= '0;
            rd_lat   <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            if (ar_hs) begin
                rd_id    <= arid;
                rd_addr  <= araddr;
                rd_len   <= arlen;
                rd_size  <= arsize;
                rd_burst <= arburst;
                rd_beat  <= '0;
                rd_lat   <= LAT_LOAD;
            end else if (rd_state == R_WAIT) begin
                rd_lat <= rd_lat - 4'd1;
            end else if (r_hs && !rd_last_beat) begin
                rd_beat <= rd_beat + 8'd1;
                rd_addr <= rd_addr_nxt;
            end
            if (rd_load) begin
                rdata_q <= (rd_fetch_resp == RESP_OKAY) ? mem[rd_idx] : '0;
                rresp_q <= rd_fetch_resp;
            end
        end
    end

    // ---------------- write channel ----------------
    wr_state_e         wr_state, wr_state_nxt;
    logic [ID_W-1:0]   wr_id;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic [7:0]        wr_len, wr_beat;
    logic [2:0]        wr_size;
    logic [1:0]        wr_burst, wr_resp, w_beat_resp;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_merged;
    logic              aw_hs, w_hs, b_hs, wr_last_beat;

    ysyx_axi4_burst_addr #(.ADDR_W(ADDR_W)) u_wr_addr (
        .addr      (wr_addr),
        .size      (wr_size),
        .len       (wr_len),
        .burst     (wr_burst),
        .next_addr (wr_addr_nxt)
    );

    assign aw_hs        = awvalid && awready;
    assign w_hs         = wvalid && wready;
    assign b_hs         = bvalid && bready;
    assign wr_last_beat = (wr_beat == wr_len);
    assign wr_idx       = word_idx(wr_addr);

    always_comb begin
        w_beat_resp = beat_resp(wr_addr, wr_burst, wr_size, wr_len);
        if (wlast != wr_last_beat)
            w_beat_resp = resp_max(w_beat_resp, RESP_SLVERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_state <= W_IDLE;
        else        wr_state <= wr_state_nxt;
    end

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE:  if (aw_hs) wr_state_nxt = W_DATA;
            W_DATA:  if (w_hs && wr_last_beat) wr_state_nxt = W_RESP;
            W_RESP:  if (b_hs) wr_state_nxt = W_IDLE;
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (wr_state)
            W_IDLE:  awready = run_q;
            W_DATA:  wready  = 1'b1;
            W_RESP:  bvalid  = 1'b1;
            default: ;
        endcase
    end

    assign bid   = wr_id;
    assign bresp = bvalid ? wr_resp : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_id    <= '0;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
            wr_beat  <= '0;
            wr_resp  <= RESP_OKAY;
        end else if (aw_hs) begin
            wr_id    <= awid;
            wr_addr  <= awaddr;
            wr_len   <= awlen;
            wr_size  <= awsize;
            wr_burst <= awburst;
            wr_beat  <= '0;
            wr_resp  <= RESP_OKAY;
        end else if (w_hs) begin
            wr_resp <= resp_max(wr_resp, w_beat_resp);
            if (!wr_last_beat) begin
                wr_beat <= wr_beat + 8'd1;
                wr_addr <= wr_addr_nxt;
            end
        end
    end

    always_comb begin
        wr_merged = mem[wr_idx];
        for (int i = 0; i < DATA_W/8; i++)
            if (wstrb[i]) wr_merged[i*8 +: 8] = wdata[i*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (w_hs && (w_beat_resp == RESP_OKAY))
            mem[wr_idx] <= wr_merged;
    end

endmodule

// File: tb/tb_ysyx_axi4_mem_slave.sv
// Randomized self-checking bench for ysyx_axi4_mem_slave against a
// burst-rule reference model of a 64-word test region.
module tb_ysyx_axi4_mem_slave;

    localparam int              LAT          = 2;
    localparam logic [31:0]     BASE         = 32'h8000_0000;
    localparam int              MEM_BYTES    = 65536;
    localparam longint unsigned TOP          = 64'h8000_0000 + 64'd65536;
    localparam int              REGION_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  arid = '0, awid = '0, rid, bid;
    logic [31:0] araddr = '0, awaddr = '0;
    logic [7:0]  arlen = '0, awlen = '0, wstrb = '0;
    logic [2:0]  arsize = '0, awsize = '0;
    logic [1:0]  arburst = '0, awburst = '0, rresp, bresp;
    logic        arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
    logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic        bvalid, bready = 1'b0;
    logic [63:0] rdata, wdata = '0;

    always #5 clk = ~clk;

    ysyx_axi4_mem_slave #(
        .ADDR_W(32), .DATA_W(64), .ID_W(4), .BASE_ADDR(BASE),
        .MEM_BYTES(MEM_BYTES), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] ref_mem [REGION_WORDS];
    logic [63:0] wd_buf  [16];
    logic [7:0]  ws_buf  [16];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // address of beat i, straight from the burst arithmetic rules
    function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [2:0] size,
                                               input logic [7:0] len, input logic [1:0] burst,
                                               input int i);
        longint unsigned step, wb, lo, av, ii;
        av   = 64'(a);
        ii   = 64'(i);
        step = 64'd1 << size;
        case (burst)
            2'b00: return a;
            2'b10: begin
                wb = (64'(len) + 64'd1) * step;
                lo = (av / wb) * wb;
                return 32'(lo + ((av - lo) + ii * step) % wb);
            end
            default: return 32'(av + ii * step);
        endcase
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst,
                                              input int i);
        logic [31:0] ba;
        logic [1:0]  r;
        ba = model_addr(a, size, len, burst, i);
        r  = 2'b00;
        if (size > 3'd3 || burst == 2'b11 ||
            (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)))
            r = 2'b10;
        if (64'(ba) < 64'(BASE) || 64'(ba) >= TOP)
            r = 2'b11;
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"}, {56'd0, arready, rvalid, rlast, awready, wready, bvalid, rresp}, 64'd0);
        check_val({tag, "_ids"}, {54'd0, bresp, rid, bid}, 64'd0);
        check_val({tag, "_rdata"}, rdata, 64'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id,
                           input int stall_beat, input int stall_cycles);
        int          k, idx;
        logic [31:0] ba;
        logic [1:0]  er;
        logic [63:0] ed;
        logic        chk_data;
        araddr = a; arlen = len; arsize = size; arburst = burst; arid = id;
        arvalid = 1'b1; rready = 1'b1;
        k = 0;
        while (!arready && k < 50) begin @(posedge clk); #1; k++; end
        check_val("ar_ready", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 50) begin @(posedge clk); #1; k++; end
        check_val("r_first_lat", 64'(k), 64'(LAT));
        for (int i = 0; i <= int'(len); i++) begin
            ba       = model_addr(a, size, len, burst, i);
            er       = model_resp(a, size, len, burst, i);
            idx      = int'((ba - BASE) >> 3);
            chk_data = (er != 2'b00) || (idx >= 0 && idx < REGION_WORDS);
            ed       = (er == 2'b00 && chk_data) ? ref_mem[idx] : 64'd0;
            if (i == stall_beat && stall_cycles > 0) begin
                rready = 1'b0;
                repeat (stall_cycles) begin
                    check_val("r_hold_valid", 64'(rvalid), 64'd1);
                    if (chk_data) check_val("r_hold_data", rdata, ed);
                    check_val("r_hold_last", 64'(rlast), 64'(i == int'(len)));
                    @(posedge clk); #1;
                end
                rready = 1'b1;
            end
            check_val("r_valid", 64'(rvalid), 64'd1);
            if (chk_data) check_val("r_data", rdata, ed);
            check_val("r_resp", 64'(rresp), 64'(er));
            check_val("r_last", 64'(rlast), 64'(i == int'(len)));
            check_val("r_id", 64'(rid), 64'(id));
            @(posedge clk); #1;
        end
        rready = 1'b0;
        check_val("r_done", 64'({rvalid, arready}), 64'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id,
                            input int bad_beat, input int b_delay, input int abort_beat);
        int          k, idx;
        logic [31:0] ba;
        logic [1:0]  er, worst;
        awaddr = a; awlen = len; awsize = size; awburst = burst; awid = id;
        awvalid = 1'b1;
        k = 0;
        while (!awready && k < 50) begin @(posedge clk); #1; k++; end
        check_val("aw_ready", 64'(awready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        check_val("w_ready_t1", 64'({awready, wready}), 64'd1);
        worst = 2'b00;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wdata  = wd_buf[i];
            wstrb  = ws_buf[i];
            wlast  = (i == int'(len)) ^ (i == bad_beat);
            if (i == abort_beat) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("rst_abort");
                wvalid = 1'b0; wlast = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check_val("rst_rel_pre", 64'(awready), 64'd0);
                @(posedge clk); #1;
                check_val("rst_rel_aw", 64'({awready, arready}), 64'd3);
                return;
            end
            ba = model_addr(a, size, len, burst, i);
            er = model_resp(a, size, len, burst, i);
            if (i == bad_beat) er = (er > 2'b10) ? er : 2'b10;
            if (er > worst) worst = er;
            if (er == 2'b00) begin
                idx = int'((ba - BASE) >> 3);
                if (idx >= 0 && idx < REGION_WORDS)
                    for (int b = 0; b < 8; b++)
                        if (ws_buf[i][b]) ref_mem[idx][b*8 +: 8] = wd_buf[i][b*8 +: 8];
            end
            check_val("w_ready", 64'({awready, wready}), 64'd1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        check_val("b_valid", 64'({awready, wready, bvalid}), 64'd1);
        check_val("b_resp", 64'(bresp), 64'(worst));
        check_val("b_id", 64'(bid), 64'(id));
        bready = 1'b0;
        repeat (b_delay) begin
            @(posedge clk); #1;
            check_val("b_hold", 64'({bvalid, bresp}), 64'({1'b1, worst}));
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check_val("b_done", 64'({bvalid, awready}), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("ready_pre_edge", 64'({arready, awready}), 64'd0);
        @(posedge clk); #1;
        check_val("ready_post_edge", 64'({arready, awready}), 64'd3);

        // fill the 64-word test region with known data
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 16; i++) begin
                wd_buf[i] = {$urandom, $urandom};
                ws_buf[i] = 8'hFF;
            end
            do_write(BASE + 32'(blk * 128), 8'd15, 3'd3, 2'b01, 4'(blk), -1, 0, -1);
        end

        wd_buf[0] = 64'h1122_3344_5566_7788; ws_buf[0] = 8'hFF;
        do_write(BASE + 32'h8, 8'd0, 3'd3, 2'b01, 4'd3, -1, 0, -1);
        do_read(BASE + 32'h8, 8'd0, 3'd3, 2'b01, 4'd5, -1, 0);
        check_val("preload_model", ref_mem[1], 64'h1122_3344_5566_7788);

        for (int i = 0; i < 4; i++) begin wd_buf[i] = 64'(i); ws_buf[i] = 8'hFF; end
        do_write(BASE + 32'h100, 8'd3, 3'd3, 2'b01, 4'd7, -1, 0, -1);
        do_read(BASE + 32'h100, 8'd3, 3'd3, 2'b01, 4'd7, -1, 0);

        wd_buf[0] = 64'hAABB_CCDD_0000_0000; ws_buf[0] = 8'hF0;
        do_write(BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'd1, -1, 0, -1);
        do_read(BASE, 8'd0, 3'd3, 2'b01, 4'd2, -1, 0);

        do_read(BASE + 32'h18, 8'd3, 3'd3, 2'b10, 4'd9, -1, 0);
        do_read(BASE + 32'h20, 8'd3, 3'd3, 2'b11, 4'd4, -1, 0);

        do_read(BASE, 8'd7, 3'd3, 2'b01, 4'd6, 3, 5);
        for (int i = 0; i < 2; i++) begin wd_buf[i] = {$urandom, $urandom}; ws_buf[i] = 8'hFF; end
        do_write(BASE + 32'h1C0, 8'd1, 3'd3, 2'b01, 4'd8, -1, 3, -1);

        do_read(32'h0000_0000, 8'd0, 3'd3, 2'b01, 4'd10, -1, 0);
        wd_buf[0] = 64'hDEAD_BEEF_DEAD_BEEF; ws_buf[0] = 8'hFF;
        do_write(32'h0000_0000, 8'd0, 3'd3, 2'b01, 4'd11, -1, 0, -1);

        for (int i = 0; i < 3; i++) begin wd_buf[i] = {$urandom, $urandom}; ws_buf[i] = 8'hFF; end
        do_write(BASE + 32'h80, 8'd2, 3'd3, 2'b01, 4'd12, 1, 0, -1);
        do_read(BASE + 32'h80, 8'd2, 3'd3, 2'b01, 4'd12, -1, 0);

        for (int i = 0; i < 8; i++) begin wd_buf[i] = {$urandom, $urandom}; ws_buf[i] = 8'hFF; end
        do_write(BASE + 32'h40, 8'd7, 3'd3, 2'b01, 4'd13, -1, 0, 2);
        do_read(BASE + 32'h40, 8'd7, 3'd3, 2'b01, 4'd13, -1, 0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] bu;
            logic [2:0] sz;
            logic [7:0] ln;
            int         step, off, sel, bad;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      bu = 2'b11;
            else if (sel == 1) bu = 2'b00;
            else if (sel < 5)  bu = 2'b10;
            else               bu = 2'b01;
            sz   = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            step = 1 << sz;
            case (bu)
                2'b10: case ($urandom_range(0, 4))
                    0: ln = 8'd1;
                    1: ln = 8'd3;
                    2: ln = 8'd7;
                    3: ln = 8'd15;
                    default: ln = 8'd2;
                endcase
                2'b01:   ln = 8'($urandom_range(0, 7));
                default: ln = 8'($urandom_range(0, 3));
            endcase
            if (bu == 2'b01)
                off = int'($urandom_range(0, (512 - (int'(ln) + 1) * step) / step)) * step;
            else
                off = int'($urandom_range(0, 512 / step - 1)) * step;
            if ($urandom_range(0, 1) == 0) begin
                do_read(BASE + 32'(off), ln, sz, bu, 4'($urandom_range(0, 15)),
                        int'($urandom_range(0, int'(ln))), int'($urandom_range(0, 3)));
            end else begin
                for (int i = 0; i <= int'(ln); i++) begin
                    wd_buf[i] = {$urandom, $urandom};
                    ws_buf[i] = 8'($urandom);
                end
                bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(ln))) : -1;
                do_write(BASE + 32'(off), ln, sz, bu, 4'($urandom_range(0, 15)),
                         bad, int'($urandom_range(0, 2)), -1);
            end
        end

        do_read(BASE, 8'd15, 3'd3, 2'b01, 4'd14, -1, 0);
        do_read(BASE + 32'h80, 8'd15, 3'd3, 2'b01, 4'd15, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
